// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter sharing one register-file write port between the ALU and load paths.
// Each source has a one-entry holding buffer; occupied buffers are granted round-robin.
module reg_wb_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         alu_valid,
    output logic                         alu_ready,
    input  logic [ADDR_WIDTH-1:0]        alu_dest,
    input  logic [DATA_WIDTH-1:0]        alu_data,
    input  logic                         mem_valid,
    output logic                         mem_ready,
    input  logic [ADDR_WIDTH-1:0]        mem_dest,
    input  logic [DATA_WIDTH-1:0]        mem_data,
    output logic                         reg_write,
    output logic [ADDR_WIDTH-1:0]        reg_write_dest,
    output logic [DATA_WIDTH-1:0]        reg_write_data,
    output logic [(2**ADDR_WIDTH)-1:0]   pending_mask
);

    logic                  r_occ0;
    logic [ADDR_WIDTH-1:0] r_dest0;
    logic [DATA_WIDTH-1:0] r_data0;
    logic                  r_occ1;
    logic [ADDR_WIDTH-1:0] r_dest1;
    logic [DATA_WIDTH-1:0] r_data1;
    logic                  r_rr;
    logic                  r_reg_write;
    logic [ADDR_WIDTH-1:0] r_reg_write_dest;
    logic [DATA_WIDTH-1:0] r_reg_write_data;

    logic w_grant0;
    logic w_grant1;
    logic w_accept0;
    logic w_accept1;

    // With both buffers full the winner is the index that did not win last time.
    assign w_grant0 = rst_n && !flush && r_occ0 && (!r_occ1 || r_rr);
    assign w_grant1 = rst_n && !flush && r_occ1 && (!r_occ0 || !r_rr);

    assign alu_ready = rst_n && !flush && (!r_occ0 || w_grant0);
    assign mem_ready = rst_n && !flush && (!r_occ1 || w_grant1);

    assign w_accept0 = alu_valid && alu_ready;
    assign w_accept1 = mem_valid && mem_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_occ0  <= 1'b0;
            r_dest0 <= '0;
            r_data0 <= '0;
        end else if (flush) begin
            r_occ0 <= 1'b0;
        end else if (w_accept0) begin
            r_occ0  <= 1'b1;
            r_dest0 <= alu_dest;
            r_data0 <= alu_data;
        end else if (w_grant0) begin
            r_occ0 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_occ1  <= 1'b0;
            r_dest1 <= '0;
            r_data1 <= '0;
        end else if (flush) begin
            r_occ1 <= 1'b0;
        end else if (w_accept1) begin
            r_occ1  <= 1'b1;
            r_dest1 <= mem_dest;
            r_data1 <= mem_data;
        end else if (w_grant1) begin
            r_occ1 <= 1'b0;
        end
    end

    // Pointer starts at 1 so the ALU wins the first tie after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr <= 1'b1;
        end else if (w_grant0) begin
            r_rr <= 1'b0;
        end else if (w_grant1) begin
            r_rr <= 1'b1;
        end
    end

    // Writes to x0 still drain their buffer but never raise the write enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_reg_write      <= 1'b0;
            r_reg_write_dest <= '0;
            r_reg_write_data <= '0;
        end else if (w_grant0) begin
            r_reg_write      <= (r_dest0 != '0);
            r_reg_write_dest <= r_dest0;
            r_reg_write_data <= r_data0;
        end else if (w_grant1) begin
            r_reg_write      <= (r_dest1 != '0);
            r_reg_write_dest <= r_dest1;
            r_reg_write_data <= r_data1;
        end else begin
            r_reg_write <= 1'b0;
        end
    end

    assign reg_write      = r_reg_write;
    assign reg_write_dest = r_reg_write_dest;
    assign reg_write_data = r_reg_write_data;

    always_comb begin
        pending_mask = '0;
        if (r_occ0)      pending_mask[r_dest0]          = 1'b1;
        if (r_occ1)      pending_mask[r_dest1]          = 1'b1;
        if (r_reg_write) pending_mask[r_reg_write_dest] = 1'b1;
        pending_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed testbench for reg_wb_arbiter: reset, contention, x0 drop, same-dest ordering,
// back-to-back single source and flush, with hand-computed expectations.
module tb_reg_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_dest;
    logic [63:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_dest;
    logic [63:0] mem_data;
    logic        reg_write;
    logic [4:0]  reg_write_dest;
    logic [63:0] reg_write_data;
    logic [31:0] pending_mask;

    int checks;
    int failures;

    localparam logic [63:0] DATA_A = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] DATA_B = 64'hBBBB_BBBB_BBBB_BBBB;

    reg_wb_arbiter #(.DATA_WIDTH(64), .ADDR_WIDTH(5)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .alu_valid      (alu_valid),
        .alu_ready      (alu_ready),
        .alu_dest       (alu_dest),
        .alu_data       (alu_data),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_dest       (mem_dest),
        .mem_data       (mem_data),
        .reg_write      (reg_write),
        .reg_write_dest (reg_write_dest),
        .reg_write_data (reg_write_data),
        .pending_mask   (pending_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic av, input logic [4:0] ad, input logic [63:0] adt,
                                 input logic mv, input logic [4:0] md, input logic [63:0] mdt,
                                 input logic fl);
        alu_valid = av;
        alu_dest  = ad;
        alu_data  = adt;
        mem_valid = mv;
        mem_dest  = md;
        mem_data  = mdt;
        flush     = fl;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // Reset held two cycles with an ALU request present, then a single ALU write.
        rst_n = 1'b0;
        applyStimulus(1'b1, 5'd5, 64'h1111, 1'b0, 5'd0, 64'd0, 1'b0);
        tick();
        checkOutput("rst_alu_ready", 64'(alu_ready), 64'd0);
        checkOutput("rst_reg_write", 64'(reg_write), 64'd0);
        checkOutput("rst_pending", 64'(pending_mask), 64'd0);
        tick();
        rst_n = 1'b1;
        applyStimulus(1'b1, 5'd5, 64'h1111, 1'b0, 5'd0, 64'd0, 1'b0);
        checkOutput("first_alu_ready", 64'(alu_ready), 64'd1);
        tick();
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);
        checkOutput("first_c1_reg_write", 64'(reg_write), 64'd0);
        checkOutput("first_c1_pending", 64'(pending_mask), 64'h20);
        tick();
        checkOutput("first_c2_reg_write", 64'(reg_write), 64'd1);
        checkOutput("first_c2_dest", 64'(reg_write_dest), 64'd5);
        checkOutput("first_c2_data", reg_write_data, 64'h1111);
        checkOutput("first_c2_pending", 64'(pending_mask), 64'h20);
        tick();
        checkOutput("first_c3_reg_write", 64'(reg_write), 64'd0);
        checkOutput("first_c3_pending", 64'(pending_mask), 64'd0);

        // Contention: both sources valid every cycle, ALU wins first.
        doReset();
        applyStimulus(1'b1, 5'd6, DATA_A, 1'b1, 5'd7, DATA_B, 1'b0);
        checkOutput("cont_c0_alu_ready", 64'(alu_ready), 64'd1);
        checkOutput("cont_c0_mem_ready", 64'(mem_ready), 64'd1);
        tick();
        for (int i = 1; i <= 6; i++) begin
            checkOutput("cont_alu_ready", 64'(alu_ready), (i % 2 == 1) ? 64'd1 : 64'd0);
            checkOutput("cont_mem_ready", 64'(mem_ready), (i % 2 == 0) ? 64'd1 : 64'd0);
            if (i >= 2) begin
                checkOutput("cont_reg_write", 64'(reg_write), 64'd1);
                checkOutput("cont_dest", 64'(reg_write_dest), (i % 2 == 0) ? 64'd6 : 64'd7);
                checkOutput("cont_data", reg_write_data, (i % 2 == 0) ? DATA_A : DATA_B);
            end
            tick();
        end

        // Write to x0 from the load port is consumed silently.
        doReset();
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 64'hDEAD, 1'b0);
        checkOutput("x0_c0_mem_ready", 64'(mem_ready), 64'd1);
        tick();
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);
        checkOutput("x0_c1_pending", 64'(pending_mask), 64'd0);
        checkOutput("x0_c1_mem_ready", 64'(mem_ready), 64'd1);
        tick();
        checkOutput("x0_c2_reg_write", 64'(reg_write), 64'd0);
        checkOutput("x0_c2_pending", 64'(pending_mask), 64'd0);
        tick();
        checkOutput("x0_c3_reg_write", 64'(reg_write), 64'd0);

        // Same destination from both ports in one cycle: ALU data first, load data last.
        doReset();
        applyStimulus(1'b1, 5'd5, 64'h1, 1'b1, 5'd5, 64'h2, 1'b0);
        tick();
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);
        checkOutput("same_c1_pending", 64'(pending_mask), 64'h20);
        tick();
        checkOutput("same_c2_reg_write", 64'(reg_write), 64'd1);
        checkOutput("same_c2_data", reg_write_data, 64'h1);
        checkOutput("same_c2_pending", 64'(pending_mask), 64'h20);
        tick();
        checkOutput("same_c3_reg_write", 64'(reg_write), 64'd1);
        checkOutput("same_c3_dest", 64'(reg_write_dest), 64'd5);
        checkOutput("same_c3_data", reg_write_data, 64'h2);
        checkOutput("same_c3_pending", 64'(pending_mask), 64'h20);
        tick();
        checkOutput("same_c4_reg_write", 64'(reg_write), 64'd0);
        checkOutput("same_c4_pending", 64'(pending_mask), 64'd0);

        // Back-to-back ALU writes to x1..x8 with no bubbles.
        doReset();
        for (int k = 0; k <= 9; k++) begin
            if (k <= 7)
                applyStimulus(1'b1, 5'(k + 1), 64'(256 + k + 1), 1'b0, 5'd0, 64'd0, 1'b0);
            else
                applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);
            if (k <= 7)
                checkOutput("b2b_alu_ready", 64'(alu_ready), 64'd1);
            if (k >= 2) begin
                checkOutput("b2b_reg_write", 64'(reg_write), 64'd1);
                checkOutput("b2b_dest", 64'(reg_write_dest), 64'(k - 1));
                checkOutput("b2b_data", reg_write_data, 64'(256 + k - 1));
            end
            tick();
        end
        checkOutput("b2b_end_reg_write", 64'(reg_write), 64'd0);

        // Flush with both buffers full and a write already registered.
        doReset();
        applyStimulus(1'b1, 5'd3, 64'h33, 1'b1, 5'd4, 64'h44, 1'b0);
        tick();
        applyStimulus(1'b1, 5'd9, 64'h99, 1'b0, 5'd0, 64'd0, 1'b0);
        checkOutput("fl_c1_pending", 64'(pending_mask), 64'h18);
        checkOutput("fl_c1_alu_ready", 64'(alu_ready), 64'd1);
        tick();
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd10, 64'hAA, 1'b1);
        checkOutput("fl_c2_alu_ready", 64'(alu_ready), 64'd0);
        checkOutput("fl_c2_mem_ready", 64'(mem_ready), 64'd0);
        checkOutput("fl_c2_reg_write", 64'(reg_write), 64'd1);
        checkOutput("fl_c2_dest", 64'(reg_write_dest), 64'd3);
        checkOutput("fl_c2_data", reg_write_data, 64'h33);
        checkOutput("fl_c2_pending", 64'(pending_mask), 64'h218);
        tick();
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);
        checkOutput("fl_c3_reg_write", 64'(reg_write), 64'd0);
        checkOutput("fl_c3_pending", 64'(pending_mask), 64'd0);
        tick();
        checkOutput("fl_c4_reg_write", 64'(reg_write), 64'd0);
        applyStimulus(1'b1, 5'd11, 64'hB1, 1'b1, 5'd12, 64'hC2, 1'b0);
        tick();
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);
        checkOutput("fl_rr_alu_ready", 64'(alu_ready), 64'd0);
        checkOutput("fl_rr_mem_ready", 64'(mem_ready), 64'd1);
        tick();
        checkOutput("fl_rr_first_dest", 64'(reg_write_dest), 64'd12);
        checkOutput("fl_rr_first_data", reg_write_data, 64'hC2);
        tick();
        checkOutput("fl_rr_second_dest", 64'(reg_write_dest), 64'd11);
        checkOutput("fl_rr_second_write", 64'(reg_write), 64'd1);
        tick();
        checkOutput("fl_rr_idle", 64'(reg_write), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
